sumador_restador_serie: RTL and testbench

Parametrised bit-serial adder/subtractor, the multi-bit sequential successor of the single-bit adder/subtractor cells in the Sumador-Restador block. It latches two WIDTH-bit operands, a mode and a carry/borrow-in on a start handshake. It then processes one bit per clock, LSB first, through a single full-adder slice with a registered carry. It reports sum/difference, carry/borrow-out and signed overflow with a one-cycle done pulse, and is intended as a low-area arithmetic unit for datapaths that can tolerate WIDTH-cycle latency.

---
 rtl/sumador_restador_serie.sv | 143 ++++++++++++++
 tb/tb_sumador_restador_serie.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_restador_serie.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry,
// operands consumed LSB first, result and flags published once per operation.
module sumador_restador_serie #(
   parameter int WIDTH = 8
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_start,
   input  logic             in_mode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_pi,
   output logic             out_busy,
   output logic             out_done,
   output logic [WIDTH-1:0] out_s,
   output logic             out_po,
   output logic             out_ov
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             po_q, po_d;
   logic             ov_q, ov_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic a_bit_s, b_bit_s, sum_bit_s, carry_nxt_s;

   // Full-adder slice; B is inverted in subtract mode so the slice computes A + ~B + ~bi.
   always_comb begin
      a_bit_s     = a_q[0];
      b_bit_s     = b_q[0] ^ mode_q;
      sum_bit_s   = a_bit_s ^ b_bit_s ^ carry_q;
      carry_nxt_s = maj3(a_bit_s, b_bit_s, carry_q);
   end

   // Next-state logic for the sequencer, datapath shift registers and result flags.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      mode_d  = mode_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      s_d     = s_q;
      po_d    = po_q;
      ov_d    = ov_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (in_start) begin
               a_d     = in_a;
               b_d     = in_b;
               mode_d  = in_mode;
               carry_d = in_pi ^ in_mode;
               cnt_d   = '0;
               r_d     = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            carry_d = carry_nxt_s;
            r_d     = {sum_bit_s, r_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            if (cnt_q == CNT_LAST) begin
               // carry_q here is the carry into the MSB, carry_nxt_s the carry out of it
               cnt_d   = '0;
               s_d     = {sum_bit_s, r_q[WIDTH-1:1]};
               po_d    = carry_nxt_s ^ mode_q;
               ov_d    = carry_q ^ carry_nxt_s;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         mode_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         s_q     <= '0;
         po_q    <= 1'b0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         mode_q  <= mode_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         s_q     <= s_d;
         po_q    <= po_d;
         ov_q    <= ov_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out_busy = busy_q;
   assign out_done = done_q;
   assign out_s    = s_q;
   assign out_po   = po_q;
   assign out_ov   = ov_q;

endmodule

// File: tb/tb_sumador_restador_serie.sv
// Self-checking bench for sumador_restador_serie at WIDTH 2, 8 and 32 against an arithmetic reference.
module tb_sumador_restador_serie;

   logic        clk;
   logic        rst_n;
   logic        start2, start8, start32;
   logic        mode, pi;
   logic [31:0] a_bus, b_bus;

   logic        busy2, done2, po2, ov2;
   logic [1:0]  s2;
   logic        busy8, done8, po8, ov8;
   logic [7:0]  s8;
   logic        busy32, done32, po32, ov32;
   logic [31:0] s32;

   int checks = 0;
   int errors = 0;

   sumador_restador_serie #(.WIDTH(2)) dut2 (
      .in_clk(clk), .in_rst_n(rst_n), .in_start(start2), .in_mode(mode),
      .in_a(a_bus[1:0]), .in_b(b_bus[1:0]), .in_pi(pi),
      .out_busy(busy2), .out_done(done2), .out_s(s2), .out_po(po2), .out_ov(ov2));

   sumador_restador_serie #(.WIDTH(8)) dut8 (
      .in_clk(clk), .in_rst_n(rst_n), .in_start(start8), .in_mode(mode),
      .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_pi(pi),
      .out_busy(busy8), .out_done(done8), .out_s(s8), .out_po(po8), .out_ov(ov8));

   sumador_restador_serie #(.WIDTH(32)) dut32 (
      .in_clk(clk), .in_rst_n(rst_n), .in_start(start32), .in_mode(mode),
      .in_a(a_bus), .in_b(b_bus), .in_pi(pi),
      .out_busy(busy32), .out_done(done32), .out_s(s32), .out_po(po32), .out_ov(ov32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic int wid(input int idx);
      case (idx)
         0:       return 2;
         1:       return 8;
         default: return 32;
      endcase
   endfunction

   // Reference: integer add/subtract, borrow = negative difference, overflow from operand/result signs.
   function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic md, input logic p,
                                     output logic [31:0] s, output logic po, output logic ov);
      logic [63:0] mask, am, bm, full;
      logic        sa, sb, ss;
      mask = (64'd1 << w) - 64'd1;
      am   = {32'd0, a} & mask;
      bm   = {32'd0, b} & mask;
      if (!md) begin
         full = am + bm + {63'd0, p};
         po   = full[w];
      end else begin
         full = am - bm - {63'd0, p};
         po   = full[63];
      end
      s  = full[31:0] & mask[31:0];
      sa = am[w-1];
      sb = bm[w-1];
      ss = s[w-1];
      ov = md ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
   endfunction

   task automatic set_start(input int idx, input logic v);
      case (idx)
         0:       start2  = v;
         1:       start8  = v;
         default: start32 = v;
      endcase
   endtask

   task automatic sample(input int idx, output logic d, output logic bz,
                         output logic [31:0] s, output logic po, output logic ov);
      case (idx)
         0:       begin d = done2;  bz = busy2;  s = {30'd0, s2}; po = po2;  ov = ov2;  end
         1:       begin d = done8;  bz = busy8;  s = {24'd0, s8}; po = po8;  ov = ov8;  end
         default: begin d = done32; bz = busy32; s = s32;         po = po32; ov = ov32; end
      endcase
   endtask

   // Issues one operation and reports latency, busy cycles, results and whether done lingered.
   task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic md, input logic p,
                         output int lat, output int bcnt, output logic [31:0] s,
                         output logic po, output logic ov, output logic done_after);
      logic d, bz;
      @(negedge clk);
      a_bus = a; b_bus = b; mode = md; pi = p;
      set_start(idx, 1'b1);
      @(negedge clk);
      set_start(idx, 1'b0);
      lat = 0; bcnt = 0;
      sample(idx, d, bz, s, po, ov);
      while (!d && lat < wid(idx) + 4) begin
         if (bz) bcnt++;
         @(negedge clk);
         lat++;
         sample(idx, d, bz, s, po, ov);
      end
      begin
         logic d2, bz2, po2_l, ov2_l;
         logic [31:0] s2_l;
         @(negedge clk);
         sample(idx, d2, bz2, s2_l, po2_l, ov2_l);
         done_after = d2;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (s8 !== 8'h00)  begin errors++; $display("FAIL reset_s: got %h want 00", s8); end
      checks++; if (po8 !== 1'b0)  begin errors++; $display("FAIL reset_po: got %b want 0", po8); end
      checks++; if (ov8 !== 1'b0)  begin errors++; $display("FAIL reset_ov: got %b want 0", ov8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done8); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      logic [7:0] ta[3], tb_[3], es[3];
      logic       tp[3], epo[3], eov[3];
      int lat, bcnt;
      logic [31:0] s; logic po, ov, da;
      ta = '{8'h3C, 8'h7F, 8'hFF}; tb_ = '{8'h05, 8'h01, 8'h01}; tp = '{1'b0, 1'b0, 1'b1};
      es = '{8'h41, 8'h80, 8'h01}; epo = '{1'b0, 1'b0, 1'b1}; eov = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         run_op(1, {24'd0, ta[i]}, {24'd0, tb_[i]}, 1'b0, tp[i], lat, bcnt, s, po, ov, da);
         checks++;
         if (lat !== 8 || bcnt !== 8 || da !== 1'b0 || s[7:0] !== es[i] || po !== epo[i] || ov !== eov[i]) begin
            errors++;
            $display("FAIL add_%0d: got lat=%0d busy=%0d done2=%b s=%h po=%b ov=%b want lat=8 busy=8 done2=0 s=%h po=%b ov=%b",
                     i, lat, bcnt, da, s[7:0], po, ov, es[i], epo[i], eov[i]);
         end
      end
   endtask

   task automatic test_subtract();
      logic [7:0] ta[3], tb_[3], es[3];
      logic       tp[3], epo[3], eov[3];
      int lat, bcnt;
      logic [31:0] s; logic po, ov, da;
      ta = '{8'h05, 8'h80, 8'h00}; tb_ = '{8'h07, 8'h01, 8'h00}; tp = '{1'b0, 1'b0, 1'b1};
      es = '{8'hFE, 8'h7F, 8'hFF}; epo = '{1'b1, 1'b0, 1'b1}; eov = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         run_op(1, {24'd0, ta[i]}, {24'd0, tb_[i]}, 1'b1, tp[i], lat, bcnt, s, po, ov, da);
         checks++;
         if (lat !== 8 || bcnt !== 8 || da !== 1'b0 || s[7:0] !== es[i] || po !== epo[i] || ov !== eov[i]) begin
            errors++;
            $display("FAIL sub_%0d: got lat=%0d busy=%0d done2=%b s=%h po=%b ov=%b want lat=8 busy=8 done2=0 s=%h po=%b ov=%b",
                     i, lat, bcnt, da, s[7:0], po, ov, es[i], epo[i], eov[i]);
         end
      end
   endtask

   task automatic test_ignore_midrun();
      int n;
      logic d, bz, po, ov;
      logic [31:0] s;
      @(negedge clk);
      a_bus = 32'h3C; b_bus = 32'h05; mode = 1'b0; pi = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; n = 0;
      repeat (3) begin @(negedge clk); n++; end
      start8 = 1'b1; a_bus = 32'hFF; b_bus = 32'hFF; mode = 1'b1; pi = 1'b1;
      @(negedge clk); n++;
      start8 = 1'b0;
      sample(1, d, bz, s, po, ov);
      while (!d && n < 20) begin @(negedge clk); n++; sample(1, d, bz, s, po, ov); end
      checks++;
      if (n !== 8 || s[7:0] !== 8'h41 || po !== 1'b0 || ov !== 1'b0) begin
         errors++;
         $display("FAIL ignore_midrun: got lat=%0d s=%h po=%b ov=%b want lat=8 s=41 po=0 ov=0", n, s[7:0], po, ov);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n, m;
      logic d, bz, po, ov;
      logic [31:0] s;
      @(negedge clk);
      a_bus = 32'h05; b_bus = 32'h07; mode = 1'b1; pi = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; n = 0;
      sample(1, d, bz, s, po, ov);
      while (!d && n < 20) begin @(negedge clk); n++; sample(1, d, bz, s, po, ov); end
      checks++;
      if (n !== 8 || s[7:0] !== 8'hFE || po !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: got lat=%0d s=%h po=%b ov=%b want lat=8 s=fe po=1 ov=0", n, s[7:0], po, ov);
      end
      a_bus = 32'h80; b_bus = 32'h01; mode = 1'b1; pi = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; m = 1;
      sample(1, d, bz, s, po, ov);
      while (!d && m < 20) begin @(negedge clk); m++; sample(1, d, bz, s, po, ov); end
      checks++;
      if (m !== 9 || s[7:0] !== 8'h7F || po !== 1'b0 || ov !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: got gap=%0d s=%h po=%b ov=%b want gap=9 s=7f po=0 ov=1", m, s[7:0], po, ov);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      int lat, bcnt;
      logic [31:0] s; logic po, ov, da;
      logic seen;
      @(negedge clk);
      a_bus = 32'h3C; b_bus = 32'h05; mode = 1'b0; pi = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (s8 !== 8'h00 || po8 !== 1'b0 || ov8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_midrun_clear: got s=%h po=%b ov=%b busy=%b done=%b want all 0",
                  s8, po8, ov8, busy8, done8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reset_midrun_nodone: got activity=%b want 0", seen); end
      run_op(1, 32'hFF, 32'h01, 1'b0, 1'b1, lat, bcnt, s, po, ov, da);
      checks++;
      if (lat !== 8 || s[7:0] !== 8'h01 || po !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL reset_midrun_next: got lat=%0d s=%h po=%b ov=%b want lat=8 s=01 po=1 ov=0", lat, s[7:0], po, ov);
      end
   endtask

   task automatic test_sweep();
      int idxs[3];
      int lat, bcnt, w;
      logic [31:0] a, b, s, es, msk;
      logic md, p, po, ov, da, epo, eov;
      idxs = '{0, 2, 1};
      for (int k = 0; k < 3; k++) begin
         w = wid(idxs[k]);
         msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
         for (int i = 0; i < 16; i++) begin
            a = $urandom(); b = $urandom();
            md = 1'($urandom_range(1, 0)); p = 1'($urandom_range(1, 0));
            ref_model(w, a, b, md, p, es, epo, eov);
            run_op(idxs[k], a, b, md, p, lat, bcnt, s, po, ov, da);
            checks++;
            if (lat !== w || bcnt !== w || da !== 1'b0 || (s & msk) !== es || po !== epo || ov !== eov) begin
               errors++;
               $display("FAIL sweep_w%0d_%0d: a=%h b=%h m=%b p=%b got lat=%0d busy=%0d s=%h po=%b ov=%b want lat=%0d s=%h po=%b ov=%b",
                        w, i, a & msk, b & msk, md, p, lat, bcnt, s & msk, po, ov, w, es, epo, eov);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b1; start2 = 1'b0; start8 = 1'b0; start32 = 1'b0;
      mode = 1'b0; pi = 1'b0; a_bus = 32'd0; b_bus = 32'd0;
      test_reset();
      test_add();
      test_subtract();
      test_ignore_midrun();
      test_back_to_back();
      test_reset_midrun();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
